// File: rtl/slow_mem_ctrl.sv
// Line-granular slow-memory responder: 128-bit line store, fixed LATENCY, one-cycle ready pulse.
// Optional SLOW_MEM_RDATA_HOLD_EN: mem_rdata holds the last read line between read responses.
module slow_mem_ctrl #(
   parameter int LATENCY    = 8,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready,
   output logic         mem_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   state_t                  state, state_nxt;
   logic [7:0]              cnt, cnt_nxt;
   logic                    op_wr_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [127:0]            wdata_q;
   logic                    accept, abort, wr_sel, load_rd;
   logic [DEPTH_LOG2-1:0]   idx_sel;
   logic                    unused_addr;

   logic [127:0] mem [0:(1<<DEPTH_LOG2)-1];

   // upper address bits alias onto the same lines
   assign unused_addr = ^mem_addr[27:DEPTH_LOG2];

   assign mem_ready = (state == RESP);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read | mem_write) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_nxt = RESP;
                  cnt_nxt   = 8'd0;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (!(mem_read | mem_write)) begin
               abort     = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = cnt - 8'd1;
               if (cnt == 8'd1) state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // op/index come straight from the bus when LATENCY=1 skips WAIT
      wr_sel  = accept ? mem_write : op_wr_q;
      idx_sel = accept ? mem_addr[DEPTH_LOG2-1:0] : idx_q;
      load_rd = (state_nxt == RESP) && !wr_sel;
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         op_wr_q   <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         mem_err   <= 1'b0;
         mem_rdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            op_wr_q <= mem_write;
            idx_q   <= mem_addr[DEPTH_LOG2-1:0];
            wdata_q <= mem_wdata;
         end
         if ((accept && mem_read && mem_write) || abort) mem_err <= 1'b1;
`ifdef SLOW_MEM_RDATA_HOLD_EN
         if (load_rd) mem_rdata <= mem[idx_sel];
`else
         mem_rdata <= load_rd ? mem[idx_sel] : '0;
`endif
      end
   end

   // commit at the edge ending RESP; a reset on that edge discards it
   always_ff @(posedge clk) begin
      if (!proc_reset && state == RESP && op_wr_q) mem[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_slow_mem_ctrl.sv
// Directed bench for slow_mem_ctrl: one instance at LATENCY=8, one at LATENCY=1.
module tb_slow_mem_ctrl;

   logic         clk = 1'b0;
   logic         proc_reset;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready, mem_err;
   logic         r1, w1;
   logic [27:0]  a1;
   logic [127:0] wd1, rd1;
   logic         rdy1, err1;

   int checks = 0;
   int failures = 0;

   localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] D2   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] L5   = {32{4'h5}};
   localparam logic [127:0] LA   = {32{4'hA}};
   localparam logic [127:0] LB1  = 128'h1111_0000_2222_0000_3333_0000_4444_0001;
   localparam logic [127:0] LB2  = 128'h9999_8888_7777_6666_5555_4444_3333_2222;

   always #5 clk = ~clk;

   slow_mem_ctrl #(.LATENCY(8), .DEPTH_LOG2(8)) u_dut (
      .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .mem_err(mem_err));

   slow_mem_ctrl #(.LATENCY(1), .DEPTH_LOG2(8)) u_dut1 (
      .clk(clk), .proc_reset(proc_reset), .mem_read(r1), .mem_write(w1),
      .mem_addr(a1), .mem_wdata(wd1), .mem_rdata(rd1),
      .mem_ready(rdy1), .mem_err(err1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit rd, input bit wr,
                        input logic [27:0] a, input logic [127:0] wd);
      if (sel) begin r1 = rd; w1 = wr; a1 = a; wd1 = wd; end
      else begin mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = wd; end
   endtask

   // Issues one request, measures edges to ready, checks latency and pulse width.
   task automatic req(input bit sel, input bit rd, input bit wr, input logic [27:0] a,
                      input logic [127:0] wd, input int exp_lat, input string tag,
                      output logic [127:0] rdata);
      int  n;
      bit  seen;
      n = 0;
      seen = 0;
      drive(sel, rd, wr, a, wd);
      while (!seen && n < 300) begin
         tick();
         n++;
         if ((sel ? rdy1 : mem_ready) === 1'b1) seen = 1;
      end
      rdata = sel ? rd1 : mem_rdata;
      check({tag, "_latency"}, 128'(n), 128'(exp_lat));
      drive(sel, 0, 0, '0, '0);
      tick();
      check({tag, "_pulse"}, 128'(sel ? rdy1 : mem_ready), 128'(0));
   endtask

   initial begin
      logic [127:0] rd;
      int           nrdy;
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      proc_reset = 1'b1;
      tick(); tick();
      check("rst_ready", 128'(mem_ready), 128'(0));
      check("rst_rdata", mem_rdata, '0);
      check("rst_err",   128'(mem_err), 128'(0));
      proc_reset = 1'b0;
      tick();

      // basic write then read
      req(0, 0, 1, 28'h0000_010, D1, 8, "wr1", rd);
      req(0, 1, 0, 28'h0000_010, '0, 8, "rd1", rd);
      check("rd1_data", rd, D1);
      check("rd1_err", 128'(mem_err), 128'(0));

      // aliasing: 0x105 maps onto line 0x05
      req(0, 0, 1, 28'h0000_005, D2, 8, "wr_alias", rd);
      req(0, 1, 0, 28'h0000_105, '0, 8, "rd_alias", rd);
      check("rd_alias_data", rd, D2);

      // read and write together: completes as write, flags error
      req(0, 1, 1, 28'h0000_040, ONES, 8, "both", rd);
      check("both_err", 128'(mem_err), 128'(1));
      req(0, 1, 0, 28'h0000_040, '0, 8, "both_rd", rd);
      check("both_rd_data", rd, ONES);

      // request dropped after 3 wait cycles
      drive(0, 1, 0, 28'h0000_010, '0);
      tick();
      tick(); tick(); tick();
      drive(0, 0, 0, '0, '0);
      nrdy = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (mem_ready === 1'b1) nrdy++;
      end
      check("abort_no_ready", 128'(nrdy), 128'(0));
      check("abort_err", 128'(mem_err), 128'(1));
      req(0, 1, 0, 28'h0000_010, '0, 8, "abort_rd", rd);
      check("abort_rd_data", rd, D1);

      // reset mid-wait discards a pending write
      req(0, 0, 1, 28'h0000_030, L5, 8, "pre_wr", rd);
      drive(0, 0, 1, 28'h0000_030, LA);
      tick();
      tick(); tick(); tick();
      proc_reset = 1'b1;
      drive(0, 0, 0, '0, '0);
      tick();
      check("midrst_ready", 128'(mem_ready), 128'(0));
      check("midrst_rdata", mem_rdata, '0);
      check("midrst_err", 128'(mem_err), 128'(0));
      proc_reset = 1'b0;
      nrdy = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (mem_ready === 1'b1) nrdy++;
      end
      check("midrst_no_ready", 128'(nrdy), 128'(0));
      req(0, 1, 0, 28'h0000_030, '0, 8, "midrst_rd", rd);
      check("midrst_rd_data", rd, L5);
      check("midrst_rd_err", 128'(mem_err), 128'(0));

      // LATENCY=1 instance: back-to-back reads with the request held high
      req(1, 0, 1, 28'h0000_001, LB1, 1, "l1_wr1", rd);
      req(1, 0, 1, 28'h0000_002, LB2, 1, "l1_wr2", rd);
      drive(1, 1, 0, 28'h0000_001, '0);
      tick();
      check("b2b_rdy_a", 128'(rdy1), 128'(1));
      check("b2b_data_a", rd1, LB1);
      drive(1, 1, 0, 28'h0000_002, '0);
      tick();
      check("b2b_gap_rdy", 128'(rdy1), 128'(0));
`ifdef SLOW_MEM_RDATA_HOLD_EN
      check("b2b_gap_data", rd1, LB1);
`else
      check("b2b_gap_data", rd1, '0);
`endif
      tick();
      check("b2b_rdy_b", 128'(rdy1), 128'(1));
      check("b2b_data_b", rd1, LB2);
      drive(1, 0, 0, '0, '0);
      tick();
      check("b2b_end_rdy", 128'(rdy1), 128'(0));
`ifdef SLOW_MEM_RDATA_HOLD_EN
      check("b2b_end_data", rd1, LB2);
`else
      check("b2b_end_data", rd1, '0);
`endif
      check("b2b_err", 128'(err1), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/slow_mem_ctrl.md
# slow_mem_ctrl

Line-granular memory responder that serves the cache-side slow-memory handshake (mem_read / mem_write / mem_addr[31:4] / 128-bit data / mem_ready). One instance sits behind the instruction cache and one behind the data cache in the system bench and FPGA wrapper. It replaces the behavioural slow-memory models with a synthesizable block: a 128-bit line store, a programmable fixed access latency, and a one-cycle ready pulse. It also flags protocol violations by the requesting cache.

## Interface
- LATENCY, 8, cycles from request acceptance to mem_ready pulse; legal range 1..255
- DEPTH_LOG2, 8, log2 of stored 128-bit lines; line index = mem_addr[DEPTH_LOG2+3:4]
- clk  input  1  single clock, all state on rising edge
- proc_reset  input  1  synchronous, active-high reset
- mem_read  input  1  read request from cache, held high until mem_ready
- mem_write  input  1  write request from cache, held high until mem_ready
- mem_addr  input  28  line address, bits [31:4]
- mem_wdata  input  128  write line, valid while mem_write high
- mem_rdata  output  128  read line, valid in mem_ready cycle
- mem_ready  output  1  one-cycle completion pulse
- mem_err  output  1  sticky protocol-violation flag

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: request seen at a rising edge (mem_read|mem_write) is accepted. Latch op, line index and mem_wdata. Load counter with LATENCY-1, go to WAIT (RESP directly if LATENCY=1).
- WAIT: decrement counter each cycle; at 0 go to RESP.
- RESP: mem_ready=1 for exactly this cycle.
  - Read: mem_rdata = stored line.
  - Write: latched line committed at the edge ending RESP.
  - Next state IDLE.
- Back-to-back: a request visible in the cycle after RESP is accepted normally (e.g. write-back followed by allocate read).
- Both mem_read and mem_write high at acceptance: treat as write, set mem_err.
- Request deasserted during WAIT: abort to IDLE, no commit, no ready, set mem_err.
- mem_addr/mem_wdata changing during WAIT or RESP: ignored; latched values are used.
- Address bits above DEPTH_LOG2+3 are ignored, so addresses alias modulo 2^DEPTH_LOG2 lines.
- Line storage is not cleared by reset; contents are X until written.
- mem_err clears only on reset.

## Timing
- Reset values: mem_ready=0, mem_rdata=0, mem_err=0, state IDLE, counter 0.
- Request sampled high at edge k (state IDLE) gives mem_ready high in cycle k+LATENCY (between edges k+LATENCY-1 and k+LATENCY). Example: LATENCY=1 means ready in the cycle right after acceptance.
- Minimum request-to-request spacing: LATENCY+1 edges.
- Reset asserted in any state takes effect at the next edge:
  - Pending write is discarded.
  - Ready is not issued.
  - Counter and state clear.
- mem_rdata is registered; there is no combinational path from inputs to outputs.

## Configuration
- SLOW_MEM_RDATA_HOLD_EN
  - Defined: mem_rdata keeps the last read line until the next read RESP or reset. Writes do not change it.
  - Undefined: mem_rdata is 0 in every cycle except a read RESP cycle.

## Test plan
- LATENCY=8, write 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to mem_addr 0x0000_010, then read the same address.
  - Each mem_ready pulse is 1 cycle and comes 8 cycles after acceptance.
  - The read returns that line.
  - mem_err stays 0.
- Write to line 0x005, then immediately read line 0x105 with DEPTH_LOG2=8 (aliasing): read returns the data written to 0x005.
- mem_read drop after 3 WAIT cycles: no mem_ready, mem_err=1, and a subsequent read of the target line shows old contents.
- mem_read and mem_write both high with wdata=all-ones: completes as a write, mem_err=1, and a later read returns all-ones.
- proc_reset pulsed mid-WAIT of a write of 0xAAAA…A to a line holding 0x5555…5: outputs return to 0, no ready, and a read after reset returns 0x5555…5.
- LATENCY=1, back-to-back reads with no idle gap: ready on alternate cycles. mem_rdata between pulses is 0 without SLOW_MEM_RDATA_HOLD_EN and holds the last line with it.
